// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder controller: default width and FSM state encoding.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Plain-vector aliases of the enum, kept for older consumers of the state bus.
  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_SHIFT = SHIFT;
  localparam logic [1:0] ST_DONE  = DONE;

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// One-bit full adder: two cascaded half-adder stages with the stage carries ORed together.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic ha0_sum;
  logic ha0_carry;
  logic ha1_carry;

  assign ha0_sum   = a ^ b;
  assign ha0_carry = a & b;

  assign sum       = ha0_sum ^ cin;
  assign ha1_carry = ha0_sum & cin;

  assign cout      = ha0_carry | ha1_carry;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller. It processes one bit per clock, LSB first, over WIDTH cycles.
// Defining SERIAL_ADDER_SUB_EN adds the sub input, which selects a - b (carry=1 means no borrow).
//
// state | meaning
// IDLE  | waiting for start; sum/carry hold the last result
// SHIFT | one full-adder step per cycle, WIDTH cycles
// DONE  | single-cycle done pulse, result valid
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry_r;
  logic [CW-1:0]    cnt;
  logic             sub_mode;
  logic             fa_sum;
  logic             fa_cout;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_mode = sub;
`else
  assign sub_mode = 1'b0;
`endif

  full_adder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry_r),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      carry_r <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sh    <= a;
            // Subtraction uses the inverted B operand with a carry-in of 1 (two's complement).
            b_sh    <= b ^ {WIDTH{sub_mode}};
            carry_r <= sub_mode;
            cnt     <= '0;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          sum_sh  <= (sum_sh >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
          carry_r <= fa_cout;
          cnt     <= cnt + CW'(1);
          if (cnt == LAST) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy  = (state == ST_SHIFT);
  assign done  = (state == ST_DONE);
  assign sum   = sum_sh;
  assign carry = carry_r;

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits, SHALL be >= 1.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-003 rst_n  input  1  reset; SHALL be synchronous and active-low.
REQ-004 start  input  1  request a new addition; SHALL be sampled only in IDLE.
REQ-005 a  input  WIDTH  operand A; SHALL be captured on the accepted start edge.
REQ-006 b  input  WIDTH  operand B; SHALL be captured on the accepted start edge.
REQ-007 busy  output  1  SHALL be high while the operation is in progress (SHIFT state).
REQ-008 done  output  1  SHALL be a single-cycle pulse when the result becomes valid.
REQ-009 sum  output  WIDTH  result; SHALL hold its value until the next accepted start.
REQ-010 carry  output  1  carry out of the MSB; SHALL hold with sum.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-012 IDLE with start=1 SHALL load a and b into shift registers, clear the bit counter, clear the carry register to carry-in, and go to SHIFT.
REQ-013 IDLE with start=0 SHALL remain in IDLE with all outputs held.
REQ-014 Each SHIFT cycle SHALL add the operand LSBs and the carry register through one full adder, shift the result bit into the sum MSB (LSB-first), shift both operands right, and increment the counter.
REQ-015 SHIFT SHALL last exactly WIDTH cycles; when counter equals WIDTH-1 the next state SHALL be DONE.
REQ-016 The counter SHALL be $clog2(WIDTH+1) bits wide and SHALL never wrap during an operation.
REQ-017 DONE SHALL assert done=1 for exactly one cycle, with sum/carry valid, then return to IDLE.
REQ-018 Latency: start accepted at edge k -> busy high in cycles k+1..k+WIDTH -> done high in cycle k+WIDTH+1.
REQ-019 start asserted in SHIFT or DONE SHALL be ignored (no queuing); back-to-back operations require start in IDLE.
REQ-020 Operand input changes after the accepted start SHALL NOT affect the result.
REQ-021 sum and carry SHALL equal the (WIDTH+1)-bit result of a + b (a + ~b + 1 in subtract mode).

Reset
REQ-022 rst_n=0 at a rising edge SHALL force IDLE, busy=0, done=0, sum=0, carry=0, counter=0.
REQ-023 Reset during SHIFT or DONE SHALL abort the operation with no done pulse.
REQ-024 Reset SHALL take priority over start in the same cycle.

Configuration
REQ-025 Macro SERIAL_ADDER_SUB_EN, when defined, SHALL add input port sub (1 bit, captured with a/b): sub=1 computes a - b as a + ~b + 1, carry=1 meaning no borrow.
REQ-026 Without SERIAL_ADDER_SUB_EN the sub port SHALL be absent and carry-in SHALL be 0 (pure addition).

Structure
REQ-027 A shared package serial_adder_pkg SHALL hold the FSM state enum (IDLE, SHIFT, DONE) and the default WIDTH constant.
REQ-028 The 1-bit add SHALL be a separate sub-module full_adder (a, b, cin -> sum, cout), built from two half-adder stages.

Verification
REQ-029 WIDTH=8, a=0x0F, b=0x01, start at edge k -> sum=0x10, carry=0, done only in cycle k+9, busy high in k+1..k+8.
REQ-030 WIDTH=8, a=0xFF, b=0x01 -> sum=0x00, carry=1; a=0x00, b=0x00 -> sum=0x00, carry=0.
REQ-031 start pulsed again at k+3 with a=0x55, b=0x55 -> ignored; result still from the first operation; exactly one done.
REQ-032 rst_n=0 at k+4 mid-SHIFT -> IDLE, sum=0x00, carry=0, no done; a new start then completes normally.
REQ-033 With SERIAL_ADDER_SUB_EN, sub=1, a=0x05, b=0x07 -> sum=0xFE, carry=0; a=0x07, b=0x05 -> sum=0x02, carry=1.
REQ-034 WIDTH=1, all four a/b combinations -> sum/carry match the half-adder truth table, with done at k+2.
